// File: rtl/sram_dout_serializer.sv
// Buffers SRAM read words in a small FIFO and shifts each one out MSB-first with a frame marker.
// Optional macro SERIALIZER_PARITY_EN appends an even-parity bit to every frame.
module sram_dout_serializer #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [DATA_W-1:0]             din,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic                          ser_out,
    output logic                          ser_valid,
    output logic                          frame_start,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              frame_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
`ifdef SERIALIZER_PARITY_EN
    localparam int FRAME_LEN = DATA_W + 1;
`else
    localparam int FRAME_LEN = DATA_W;
`endif
    // The parity bit, when enabled, rides in the LSB of the shift register behind the data.
    localparam int SR_W = FRAME_LEN;
    localparam int BW   = $clog2(FRAME_LEN);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

`ifdef SERIALIZER_PARITY_EN
    function automatic logic parity_f(input logic [DATA_W-1:0] word);
        return ^word;
    endfunction
`endif

    logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [LW-1:0]     level_r;
    state_t            state_r;
    logic [SR_W-1:0]   shift_r;
    logic [BW-1:0]     bit_cnt_r;
    logic [CNT_W-1:0]  frame_cnt_r;

    logic              full_s;
    logic              push_s;
    logic              pop_s;
    logic              last_bit_s;
    logic [DATA_W-1:0] head_s;
    logic [SR_W-1:0]   load_word_s;

    // Handshake, pop decision and the word presented to the shift register.
    always_comb begin
        full_s     = (level_r == LW'(FIFO_DEPTH));
        push_s     = din_valid & ~full_s;
        last_bit_s = (state_r == ST_SHIFT) && (bit_cnt_r == BW'(FRAME_LEN - 1));
        head_s     = mem_r[rd_ptr_r];
        if (start && (level_r != {LW{1'b0}}) && ((state_r == ST_IDLE) || last_bit_s)) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
`ifdef SERIALIZER_PARITY_EN
        load_word_s = {head_s, parity_f(head_s)};
`else
        load_word_s = head_s;
`endif
    end

    // FIFO storage; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Serializer FSM: load on pop, shift each edge, count frames on the last bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            shift_r     <= {SR_W{1'b0}};
            bit_cnt_r   <= {BW{1'b0}};
            frame_cnt_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        state_r   <= ST_SHIFT;
                        shift_r   <= load_word_s;
                        bit_cnt_r <= {BW{1'b0}};
                    end
                end
                ST_SHIFT: begin
                    if (last_bit_s) begin
                        frame_cnt_r <= frame_cnt_r + CNT_W'(1);
                        bit_cnt_r   <= {BW{1'b0}};
                        if (pop_s) begin
                            shift_r <= load_word_s;
                        end else begin
                            state_r <= ST_IDLE;
                            shift_r <= {SR_W{1'b0}};
                        end
                    end else begin
                        shift_r   <= {shift_r[SR_W-2:0], 1'b0};
                        bit_cnt_r <= bit_cnt_r + BW'(1);
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    shift_r   <= {SR_W{1'b0}};
                    bit_cnt_r <= {BW{1'b0}};
                end
            endcase
        end
    end

    assign busy        = (state_r == ST_SHIFT);
    assign ser_valid   = (state_r == ST_SHIFT);
    assign ser_out     = (state_r == ST_SHIFT) & shift_r[SR_W-1];
    assign frame_start = (state_r == ST_SHIFT) && (bit_cnt_r == {BW{1'b0}});
    assign din_ready   = ~full_s;
    assign fifo_level  = level_r;
    assign frame_count = frame_cnt_r;

endmodule

// File: doc/sram_dout_serializer.md
Name: sram_dout_serializer

Overview:
- Downstream consumer of the SRAM read path: accepts 8-bit words from the SRAM controller's data output through a valid/ready handshake.
- Buffers the words in a small FIFO.
- Shifts each word out MSB-first on a 1-bit serial line, with a frame marker on the first bit.
- Keeps a wrapping count of completed frames, used for debug and observation in the top-level test.

Parameters:
- DATA_W, 8: word width; matches sram_dout.
- FIFO_DEPTH, 4: buffer entries; must be a power of two, minimum 2.
- CNT_W, 8: width of frame_count.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  serializer enable; level-sensitive.
- din  input  DATA_W  word from the SRAM read path.
- din_valid  input  1  din holds a word this cycle.
- din_ready  output  1  FIFO can accept a word; equals !full.
- ser_out  output  1  serial data bit.
- ser_valid  output  1  ser_out carries a valid bit this cycle.
- frame_start  output  1  high on the first bit of each frame only.
- busy  output  1  FSM is in SHIFT.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  number of words currently in the FIFO.
- frame_count  output  CNT_W  completed frames; wraps 2^CNT_W-1 to 0.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - FIFO pointers and fifo_level = 0; FIFO contents are don't-care.
  - FSM = IDLE; shift register = 0; bit counter = 0.
  - ser_out = 0, ser_valid = 0, frame_start = 0, busy = 0, frame_count = 0, din_ready = 1.
  - A reset mid-frame discards the partial frame and all buffered words.
- Push: on a rising edge with din_valid && din_ready, din is written at the write pointer and fifo_level increments.
  - When full, din_ready = 0 and din is ignored. A same-cycle pop does not free the slot for that cycle's push.
- Pop and load: occur on the same edge. The head word is copied into the shift register, the read pointer advances, fifo_level decrements, and the bit counter is set to 0.
- Simultaneous push and pop when neither full nor empty: fifo_level is unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states are IDLE and SHIFT.
  - IDLE → SHIFT: on a clock edge where start=1 and fifo_level>0; the pop/load happens on that edge.
  - IDLE otherwise stays IDLE with ser_valid = 0.
  - SHIFT outputs:
    - ser_out = shift_reg[DATA_W-1]; ser_valid = 1; busy = 1.
    - frame_start = 1 when bit counter = 0.
  - SHIFT, each edge: shift register shifts left by one (zero fill) and the bit counter increments.
  - SHIFT, on the edge ending the last bit (counter = FRAME_LEN-1):
    - frame_count increments.
    - If start=1 and fifo_level>0: pop/load again and stay in SHIFT. Frames are back-to-back with no gap.
    - Otherwise go to IDLE.
- FRAME_LEN = DATA_W without the optional feature, DATA_W+1 with it.
- Latency: a word pushed at edge N into an empty FIFO, with the FSM idle and start=1, is loaded at edge N+1. Its MSB is visible from edge N+1 to N+2.
- start deasserted mid-frame: the current frame completes; no further pop. Frames resume when start returns high.
- Outputs are registered or decoded from state only; there is no combinational path from din or din_valid to any output except din_ready, which depends on fifo_level only.

Optional Feature:
- Macro: SERIALIZER_PARITY_EN.
- Defined: after the DATA_W data bits, one extra bit is sent in SHIFT with ser_valid = 1. It is the even parity (XOR) of the loaded word, latched at load time. FRAME_LEN = DATA_W+1, and frame_count increments after the parity bit.
- Undefined: no parity logic or state; FRAME_LEN = DATA_W.

Test Plan:
- Reset, then push 8'hA5 with start=1 → from the following edge, ser_out = 1,0,1,0,0,1,0,1 over 8 cycles with ser_valid=1. frame_start is high on the first bit only. frame_count = 1. The FSM returns to IDLE. With SERIALIZER_PARITY_EN, a 9th bit of 0 follows.
- start=0, push 8'h01, 8'h02, 8'h03, 8'h04, 8'h05 on consecutive cycles:
  - din_ready drops after the 4th push; fifo_level = 4; the 5th word is not accepted.
  - Then raise start: 32 contiguous valid bits for 01, 02, 03, 04, with frame_start at bits 0, 8, 16, 24; frame_count = 4.
- Continuous pushes with start=1 → no idle cycle between frames. Push and pop on the same edge leave fifo_level unchanged.
- Drop start at bit 3 of the 8'hFF frame while 8'h00 is buffered → the FF frame completes. 8'h00 is held (fifo_level = 1) until start returns, then it is sent.
- Assert reset mid-frame between edges → all outputs are 0 immediately, fifo_level = 0, frame_count = 0. The next pushed word is serialized from its MSB.
- Send 256 frames → frame_count wraps to 0.
